// File: rtl/decode_hazard_ctrl.sv
// rtl/decode_hazard_ctrl.sv - decode-stage register scoreboard, issue gating and flush drain
module decode_hazard_ctrl #(
   parameter int cXLEN        = 32,
   parameter int cMaxInflight = 4,
   parameter int cFlushCycles = 2
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iInstDv,
   input  logic [4:0]  iRs1Addr,
   input  logic [4:0]  iRs2Addr,
   input  logic [4:0]  iRdAddr,
   input  logic        iUseRs1,
   input  logic        iUseRs2,
   input  logic        iWritesRd,
   input  logic        iWbDv,
   input  logic [4:0]  iWbAddr,
   input  logic        iFlushPipe,
   output logic        oReady,
   output logic        oIssue,
   output logic [1:0]  oState,
   output logic [31:0] oBusyVec,
   output logic [3:0]  oInflight,
   output logic [15:0] oStallCnt,
   output logic        oWbErr
);

   typedef enum logic [1:0] {
      sRun   = 2'b00,
      sStall = 2'b01,
      sFlush = 2'b10
   } state_t;

   if (cXLEN < 32) begin : g_bad_xlen
      $error("cXLEN must be at least 32");
   end
   if (cMaxInflight < 1 || cMaxInflight > 15) begin : g_bad_inflight
      $error("cMaxInflight must be in 1..15");
   end
   if (cFlushCycles < 1 || cFlushCycles > 15) begin : g_bad_flush
      $error("cFlushCycles must be in 1..15");
   end

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_drain;
   logic [3:0]  w_drain_nxt;
   logic [31:0] r_busy;
   logic [3:0]  r_inflight;
   logic [15:0] r_stall_cnt;
   logic        r_wb_err;

   logic        w_hazard;
   logic        w_inflight_full;
   logic        w_wb_hit;
   logic        w_wb_ok;
   logic        w_wb_spurious;
   logic        w_set;
   logic        w_stall_cycle;
   logic [31:0] w_set_mask;
   logic [31:0] w_clr_mask;

   // Hazards look only at the registered scoreboard; x0 can never be busy.
   always_comb begin
      w_inflight_full = (r_inflight == 4'(cMaxInflight));
      w_hazard = (iUseRs1 & r_busy[iRs1Addr])
               | (iUseRs2 & r_busy[iRs2Addr])
               | (iWritesRd & r_busy[iRdAddr])
               | (iWritesRd & w_inflight_full);
      oReady = !iRst & (r_state != sFlush) & !iFlushPipe & !w_hazard;
      oIssue = iInstDv & oReady;

      w_wb_hit      = r_busy[iWbAddr];
      w_wb_ok       = iWbDv & w_wb_hit & (r_state != sFlush) & !iFlushPipe;
      w_wb_spurious = iWbDv & !w_wb_hit & (r_state != sFlush) & !iFlushPipe;
      w_set         = oIssue & iWritesRd & (iRdAddr != 5'd0);
      w_set_mask    = w_set   ? (32'd1 << iRdAddr) : 32'd0;
      w_clr_mask    = w_wb_ok ? (32'd1 << iWbAddr) : 32'd0;
      w_stall_cycle = iInstDv & !oReady & (r_state != sFlush);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain;
      if (iFlushPipe) begin
         w_state_nxt = sFlush;
         w_drain_nxt = 4'(cFlushCycles);
      end else begin
         case (r_state)
            sRun: begin
               if (iInstDv & w_hazard) w_state_nxt = sStall;
            end
            sStall: begin
               if (!w_hazard | !iInstDv) w_state_nxt = sRun;
            end
            sFlush: begin
               // Leave on the same edge that the drain counter reaches zero.
               if (r_drain <= 4'd1) begin
                  w_state_nxt = sRun;
                  w_drain_nxt = 4'd0;
               end else begin
                  w_drain_nxt = r_drain - 4'd1;
               end
            end
            default: w_state_nxt = sRun;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state     <= sRun;
         r_drain     <= 4'd0;
         r_busy      <= 32'd0;
         r_inflight  <= 4'd0;
         r_stall_cnt <= 16'd0;
         r_wb_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_drain  <= w_drain_nxt;
         r_wb_err <= w_wb_spurious;
         if (iFlushPipe) begin
            r_busy     <= 32'd0;
            r_inflight <= 4'd0;
         end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            case ({w_set, w_wb_ok})
               2'b10:   r_inflight <= r_inflight + 4'd1;
               2'b01:   r_inflight <= r_inflight - 4'd1;
               default: r_inflight <= r_inflight;
            endcase
         end
         if (w_stall_cycle & (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign oState    = r_state;
   assign oBusyVec  = r_busy;
   assign oInflight = r_inflight;
   assign oStallCnt = r_stall_cnt;
   assign oWbErr    = r_wb_err;

endmodule

// File: doc/decode_hazard_ctrl.md
DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 Parameter cXLEN, default 32: instruction width; used only for width checks, no data path.
REQ-002 Parameter cMaxInflight, default 4: maximum outstanding register-writing instructions; range 1..15.
REQ-003 Parameter cFlushCycles, default 2: issue-blocked drain cycles after a flush; range 1..15.
REQ-004 iClk  in  1  sole clock; all state updates on rising edge.
REQ-005 iRst  in  1  synchronous, active-high reset.
REQ-006 iInstDv  in  1  decode-stage instruction valid.
REQ-007 iRs1Addr, iRs2Addr, iRdAddr  in  5 each  decoded register addresses.
REQ-008 iUseRs1, iUseRs2, iWritesRd  in  1 each  operand-use and destination-write flags for the current instruction.
REQ-009 iWbDv  in  1  writeback valid.
REQ-010 iWbAddr  in  5  writeback destination.
REQ-011 iFlushPipe  in  1  pipeline flush request.
REQ-012 oReady  out  1  combinational; instruction can be issued this cycle.
REQ-013 oIssue  out  1  combinational; iInstDv & oReady.
REQ-014 oState  out  2  FSM state: 00 sRun, 01 sStall, 10 sFlush.
REQ-015 oBusyVec  out  32  registered scoreboard; bit n set = write to xn pending.
REQ-016 oInflight  out  4  registered count of pending writes.
REQ-017 oStallCnt  out  16  registered saturating count of stall cycles.
REQ-018 oWbErr  out  1  registered, one-cycle pulse on spurious writeback.

Function
REQ-019 Hazard = (iUseRs1 & busy[iRs1Addr]) | (iUseRs2 & busy[iRs2Addr]) | (iWritesRd & busy[iRdAddr]) | (iWritesRd & oInflight==cMaxInflight).
REQ-020 busy[0] is always 0: no set on rd=0, and x0 never causes a hazard.
REQ-021 Hazard uses registered oBusyVec only; a writeback releases the stall on the following cycle; there is no same-cycle bypass.
REQ-022 oReady = (state != sFlush) & !iFlushPipe & !Hazard.
REQ-023 On oIssue with iWritesRd and iRdAddr!=0: busy[iRdAddr] is set and oInflight is incremented.
REQ-024 On iWbDv with busy[iWbAddr]=1: busy[iWbAddr] is cleared and oInflight is decremented.
REQ-025 Issue and writeback in the same cycle leave oInflight unchanged; a set and a clear of the same bit cannot coincide, because of the WAW check.
REQ-026 iWbDv with busy[iWbAddr]=0 (including addr 0): no state change; oWbErr=1 on the next cycle.
REQ-027 FSM transitions:
- sRun -> sStall when iInstDv & Hazard.
- sStall -> sRun when !Hazard or !iInstDv.
- any state -> sFlush when iFlushPipe.
- sFlush -> sRun after cFlushCycles cycles with no further flush.
REQ-028 iFlushPipe has priority over every other event in the same cycle:
- clears all busy bits and sets oInflight=0;
- ignores any writeback in that cycle;
- forces oIssue=0;
- loads the drain counter with cFlushCycles.
REQ-029 A flush while already in sFlush reloads the drain counter.
REQ-030 In sFlush the drain counter decrements each cycle; writebacks in sFlush are ignored and raise no oWbErr; the exit to sRun occurs on the cycle the counter reaches 0.
REQ-031 oStallCnt increments each cycle with iInstDv & !oReady & state!=sFlush; it saturates at 16'hFFFF.

Reset
REQ-032 When iRst=1 on an edge:
- state=sRun, oBusyVec=0, oInflight=0, oStallCnt=0, oWbErr=0, drain counter=0.
REQ-033 While iRst=1, oReady=0 and oIssue=0.
REQ-034 iRst has priority over iFlushPipe.
REQ-035 Reset mid-stall or mid-flush discards all pending state.

Verification
REQ-036 RAW: issue rd=5 (writes); next cycle iUseRs1=1, rs1=5 -> oReady=0, oState=01; wb addr 5 -> oReady=1 one cycle later, oInflight back to 0.
REQ-037 Limit: four issues to rd=1..4 with no wb -> oInflight=4; a fifth issue with rd=6 -> stall; one wb -> the fifth issues the next cycle.
REQ-038 x0: a stream writing rd=0 and reading rs=0 -> never stalls, oBusyVec stays 0, oInflight stays 0.
REQ-039 Flush: busy={3,7}, oInflight=2, flush with simultaneous wb addr 3 -> next cycle oBusyVec=0, oInflight=0, oState=10, oReady=0 for 2 cycles, then sRun.
REQ-040 Spurious wb addr 9 with busy[9]=0 -> oWbErr=1 for exactly one cycle; oInflight unchanged.
REQ-041 Reset during sStall with oStallCnt=10 -> all outputs return to their REQ-032 values; oReady=1 after iRst falls, given no hazard.
